// File: rtl/lexington_pkg.sv
// Shared types and defaults for the core-to-AXI4-Lite bridge.
package lexington_pkg;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI_TIMEOUT    = 256;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WR_RESP,
    ST_READ,
    ST_RD_RESP,
    ST_DONE,
    ST_DRAIN
  } axi_bridge_state_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_bridge.sv
// Turns single-word DBus requests from the core into AXI4-Lite master
// transactions, stalling the core until the response (or a timeout) arrives.
module axi_lite_bridge
  import lexington_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strobe,
  output logic [31:0]               rd_data,
  output logic                      access_fault,
  output logic                      busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [31:0]               m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  // r_state is the core-facing sequence; r_phase is the AXI-side progress,
  // which keeps running on its own after a timeout until the slave answers.
  axi_bridge_state_t r_state, w_state_next;
  axi_bridge_state_t r_phase, w_phase_next;

  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic                      r_aw_done, r_w_done;
  logic [CNT_W-1:0]          r_cnt;
  logic [31:0]               r_rd_data;
  logic                      r_fault;

  logic w_req, w_accept, w_active, w_timeout;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_resp_hs;

  assign w_req     = rd_en | wr_en;
  assign w_accept  = (r_state == ST_IDLE) && w_req;
  assign w_active  = r_state inside {ST_WRITE, ST_WR_RESP, ST_READ, ST_RD_RESP};
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIMIT);

  assign w_aw_hs   = m_awvalid & m_awready;
  assign w_w_hs    = m_wvalid & m_wready;
  assign w_ar_hs   = m_arvalid & m_arready;
  assign w_b_hs    = m_bready & m_bvalid;
  assign w_r_hs    = m_rready & m_rvalid;
  assign w_resp_hs = w_b_hs | w_r_hs;

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      ST_IDLE:    if (w_accept) w_phase_next = wr_en ? ST_WRITE : ST_READ;
      ST_WRITE:   if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_phase_next = ST_WR_RESP;
      ST_WR_RESP: if (m_bvalid) w_phase_next = ST_IDLE;
      ST_READ:    if (w_ar_hs) w_phase_next = ST_RD_RESP;
      ST_RD_RESP: if (m_rvalid) w_phase_next = ST_IDLE;
      default:    w_phase_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_phase_next;
      ST_WRITE, ST_WR_RESP, ST_READ, ST_RD_RESP: begin
        // A withdrawn request still finishes on the bus but skips DONE.
        if (w_resp_hs)      w_state_next = w_req ? ST_DONE : ST_IDLE;
        else if (w_timeout) w_state_next = ST_DONE;
        else                w_state_next = w_phase_next;
      end
      ST_DONE:  w_state_next = (w_phase_next == ST_IDLE) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (w_phase_next == ST_IDLE) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      if (w_accept) begin
        r_addr    <= addr & ~(AXI_ADDR_WIDTH'(3));
        r_wdata   <= wr_data;
        r_wstrb   <= wr_strobe;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_cnt     <= CNT_W'(1);
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
        if (w_active && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_active) begin
        if (w_resp_hs) begin
          if (w_req) begin
            r_fault <= resp_is_error(w_r_hs ? m_rresp : m_bresp);
            if (w_r_hs) r_rd_data <= m_rdata;
          end
        end else if (w_timeout) begin
          r_fault   <= 1'b1;
          r_rd_data <= '0;
        end
      end
    end
  end

  assign busy         = (w_req && (r_state != ST_DONE)) || (r_state == ST_DRAIN);
  assign rd_data      = r_rd_data;
  assign access_fault = r_fault;

  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_awvalid = (r_phase == ST_WRITE) && !r_aw_done;
  assign m_wvalid  = (r_phase == ST_WRITE) && !r_w_done;
  assign m_bready  = (r_phase == ST_WR_RESP);
  assign m_arvalid = (r_phase == ST_READ);
  assign m_rready  = (r_phase == ST_RD_RESP);

endmodule
